// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_DEPTH    = 32;
  localparam int unsigned RF_NUM_READ = 2;
  localparam int unsigned RF_ADDR_W   = $clog2(RF_DEPTH);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with set-over-clear priority and a registered busy population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH         = RF_DEPTH,
  parameter int unsigned ADDR_W        = $clog2(DEPTH),
  parameter int unsigned NUM_READ      = RF_NUM_READ,
  parameter bit          HARDWIRE_ZERO = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clr,
  input  logic [ADDR_W-1:0]            i_clr_addr,
  input  logic                         i_set,
  input  logic [ADDR_W-1:0]            i_set_addr,
  input  logic [NUM_READ*ADDR_W-1:0]   i_lookup_addr,
  output logic [NUM_READ-1:0]          o_busy,
  output logic [ADDR_W:0]              o_busy_count
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_busy_count;
  logic [ADDR_W:0]  w_count_nxt;

  // Set is applied after clear so a newly issued producer wins over a retiring write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
    if (HARDWIRE_ZERO) w_busy_nxt[0] = 1'b0;
    w_count_nxt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_count_nxt = w_count_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_count_nxt;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int k = 0; k < int'(NUM_READ); k++) begin
      o_busy[k] = r_busy[i_lookup_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  assign o_busy_count = r_busy_count;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with integrated busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W        = RF_DATA_W,
  parameter int unsigned DEPTH         = RF_DEPTH,
  parameter int unsigned ADDR_W        = $clog2(DEPTH),
  parameter int unsigned NUM_READ      = RF_NUM_READ,
  parameter bit          HARDWIRE_ZERO = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         reg_write,
  input  logic [ADDR_W-1:0]            write_reg_address,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         sb_set,
  input  logic [ADDR_W-1:0]            sb_set_addr,
  output logic [ADDR_W:0]              busy_count
);

  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [NUM_READ-1:0] w_sb_busy;
  logic [ADDR_W-1:0]   w_ra;
  logic                w_wr_ok;

  assign w_wr_ok = reg_write && !(HARDWIRE_ZERO && (write_reg_address == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[write_reg_address] <= write_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH         (DEPTH),
    .ADDR_W        (ADDR_W),
    .NUM_READ      (NUM_READ),
    .HARDWIRE_ZERO (HARDWIRE_ZERO)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .i_clr         (reg_write),
    .i_clr_addr    (write_reg_address),
    .i_set         (sb_set),
    .i_set_addr    (sb_set_addr),
    .i_lookup_addr (rd_addr),
    .o_busy        (w_sb_busy),
    .o_busy_count  (busy_count)
  );

  // Read muxes; optional forwarding replaces the array value with the in-flight write.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_ra    = '0;
    for (int k = 0; k < int'(NUM_READ); k++) begin
      w_ra = rd_addr[k*ADDR_W +: ADDR_W];
      rd_data[k*DATA_W +: DATA_W] = r_regs[w_ra];
      rd_busy[k] = w_sb_busy[k];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (w_ra == write_reg_address)) begin
        rd_data[k*DATA_W +: DATA_W] = write_data;
        rd_busy[k] = sb_set && (sb_set_addr == w_ra);
      end
`endif
      if (HARDWIRE_ZERO && (w_ra == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default 32x32/2-port instance plus a 64-bit/16-deep/4-port instance without hardwired zero.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [9:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_we;
  logic [4:0]   a_wa;
  logic [31:0]  a_wd;
  logic         a_ss;
  logic [4:0]   a_sa;
  logic [5:0]   a_cnt;

  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_we;
  logic [3:0]   b_wa;
  logic [63:0]  b_wd;
  logic         b_ss;
  logic [3:0]   b_sa;
  logic [4:0]   b_cnt;

  int checks = 0;
  int failures = 0;

  regfile_mp u_dut_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .reg_write(a_we), .write_reg_address(a_wa), .write_data(a_wd),
    .sb_set(a_ss), .sb_set_addr(a_sa), .busy_count(a_cnt)
  );

  regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_READ(4), .HARDWIRE_ZERO(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .reg_write(b_we), .write_reg_address(b_wa), .write_data(b_wd),
    .sb_set(b_ss), .sb_set_addr(b_sa), .busy_count(b_cnt)
  );

  // Reference model: architectural register and busy state, updated per the write/scoreboard rules.
  logic [31:0] ma_reg [32];
  bit          ma_busy [32];
  logic [63:0] mb_reg [16];
  bit          mb_busy [16];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin ma_reg[i] = '0; ma_busy[i] = 0; end
      for (int i = 0; i < 16; i++) begin mb_reg[i] = '0; mb_busy[i] = 0; end
    end else begin
      if (a_we && a_wa != 0) begin ma_reg[a_wa] = a_wd; ma_busy[a_wa] = 0; end
      if (a_ss && a_sa != 0) ma_busy[a_sa] = 1;
      if (b_we) begin mb_reg[b_wa] = b_wd; mb_busy[b_wa] = 0; end
      if (b_ss) mb_busy[b_sa] = 1;
    end
  end

  function automatic logic [31:0] exp_a_data(input logic [4:0] ad);
    if (ad == 0) return 32'h0;
    if (BYP && a_we && ad == a_wa) return a_wd;
    return ma_reg[ad];
  endfunction

  function automatic logic exp_a_busy(input logic [4:0] ad);
    if (ad == 0) return 1'b0;
    if (BYP && a_we && ad == a_wa) return a_ss && (a_sa == ad);
    return ma_busy[ad];
  endfunction

  function automatic logic [63:0] exp_b_data(input logic [3:0] ad);
    if (BYP && b_we && ad == b_wa) return b_wd;
    return mb_reg[ad];
  endfunction

  function automatic logic exp_b_busy(input logic [3:0] ad);
    if (BYP && b_we && ad == b_wa) return b_ss && (b_sa == ad);
    return mb_busy[ad];
  endfunction

  function automatic int pop_a();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(ma_busy[i]);
    return n;
  endfunction

  function automatic int pop_b();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(mb_busy[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    a_we = 0; a_ss = 0; b_we = 0; b_ss = 0;
  endtask

  task automatic test_reset();
    reset = 1; a_we = 1; a_wa = 5'd5; a_wd = 32'hDEAD; a_ss = 1; a_sa = 5'd5;
    b_we = 1; b_wa = 4'd5; b_wd = 64'hDEAD; b_ss = 1; b_sa = 4'd5;
    a_rd_addr = '0; b_rd_addr = '0;
    repeat (2) tick();
    reset = 0; idle();
    for (int i = 0; i < 32; i++) begin
      a_rd_addr = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
        failures++;
        $display("FAIL reset_read addr=%0d got data=%h busy=%b exp data=0 busy=0", i, a_rd_data, a_rd_busy);
      end
    end
    checks++;
    if (a_cnt !== 6'd0 || b_cnt !== 5'd0) begin
      failures++;
      $display("FAIL reset_count got a=%0d b=%0d exp 0", a_cnt, b_cnt);
    end
  endtask

  task automatic test_write_read();
    a_we = 1; a_wa = 5'd7; a_wd = 32'h12345678; tick();
    a_wa = 5'd31; a_wd = 32'hCAFEBABE; tick();
    idle(); a_rd_addr = {5'd31, 5'd7}; #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h12345678 || a_rd_data[63:32] !== 32'hCAFEBABE) begin
      failures++;
      $display("FAIL write_read got p0=%h p1=%h exp 12345678 cafebabe", a_rd_data[31:0], a_rd_data[63:32]);
    end
    a_we = 1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF; a_rd_addr = '0; #1;
    checks++;
    if (a_rd_data !== 64'h0) begin
      failures++;
      $display("FAIL r0_bypass got=%h exp=0", a_rd_data);
    end
    tick(); idle(); #1;
    checks++;
    if (a_rd_data !== 64'h0) begin
      failures++;
      $display("FAIL r0_write got=%h exp=0", a_rd_data);
    end
  endtask

  task automatic test_scoreboard();
    a_ss = 1; a_sa = 5'd3; tick();
    idle(); a_rd_addr = {5'd0, 5'd3}; #1;
    checks++;
    if (a_rd_busy[0] !== 1'b1 || a_cnt !== 6'd1) begin
      failures++;
      $display("FAIL sb_set got busy=%b cnt=%0d exp 1 1", a_rd_busy[0], a_cnt);
    end
    a_we = 1; a_wa = 5'd3; a_wd = 32'hA5; tick();
    idle(); #1;
    checks++;
    if (a_rd_busy[0] !== 1'b0 || a_cnt !== 6'd0 || a_rd_data[31:0] !== 32'hA5) begin
      failures++;
      $display("FAIL sb_clear got busy=%b cnt=%0d data=%h exp 0 0 a5", a_rd_busy[0], a_cnt, a_rd_data[31:0]);
    end
    a_ss = 1; a_sa = 5'd0; tick();
    idle(); a_rd_addr = '0; #1;
    checks++;
    if (a_rd_busy !== 2'b00 || a_cnt !== 6'd0) begin
      failures++;
      $display("FAIL sb_r0 got busy=%b cnt=%0d exp 0 0", a_rd_busy, a_cnt);
    end
  endtask

  task automatic test_collision();
    a_ss = 1; a_sa = 5'd9; a_we = 1; a_wa = 5'd9; a_wd = 32'h55; tick();
    idle(); a_rd_addr = {5'd9, 5'd9}; #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h55 || a_rd_busy !== 2'b11 || a_cnt !== 6'd1) begin
      failures++;
      $display("FAIL collision got data=%h busy=%b cnt=%0d exp 55 11 1", a_rd_data[31:0], a_rd_busy, a_cnt);
    end
    for (int i = 1; i < 32; i++) begin
      a_ss = 1; a_sa = 5'(i); tick();
    end
    idle(); #1;
    checks++;
    if (a_cnt !== 6'd31) begin
      failures++;
      $display("FAIL busy_all got=%0d exp=31", a_cnt);
    end
    a_ss = 1; a_sa = 5'd5; tick(); idle(); #1;
    checks++;
    if (a_cnt !== 6'd31) begin
      failures++;
      $display("FAIL busy_reset_twice got=%0d exp=31", a_cnt);
    end
    reset = 1; tick(); reset = 0; #1;
    checks++;
    if (a_cnt !== 6'd0 || a_rd_busy !== 2'b00 || a_rd_data !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset got cnt=%0d busy=%b data=%h exp 0 0 0", a_cnt, a_rd_busy, a_rd_data);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
    a_we = 1; a_wa = 5'd4; a_wd = 32'h11; tick();
    a_wd = 32'h99; a_rd_addr = {5'd0, 5'd4}; #1;
    exp_d = BYP ? 32'h99 : 32'h11;
    checks++;
    if (a_rd_data[31:0] !== exp_d || a_rd_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h busy=%b exp=%h 0", a_rd_data[31:0], a_rd_busy[0], exp_d);
    end
    tick(); idle(); #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h99) begin
      failures++;
      $display("FAIL bypass_next_cycle got=%h exp=99", a_rd_data[31:0]);
    end
    a_we = 1; a_wa = 5'd4; a_wd = 32'h77; a_ss = 1; a_sa = 5'd4; #1;
    checks++;
    if (a_rd_busy[0] !== BYP || a_rd_data[31:0] !== (BYP ? 32'h77 : 32'h99)) begin
      failures++;
      $display("FAIL bypass_set got busy=%b data=%h exp busy=%b", a_rd_busy[0], a_rd_data[31:0], BYP);
    end
    tick(); idle(); #1;
    checks++;
    if (a_rd_busy[0] !== 1'b1 || a_cnt !== 6'd1 || a_rd_data[31:0] !== 32'h77) begin
      failures++;
      $display("FAIL bypass_set_after got busy=%b cnt=%0d data=%h exp 1 1 77", a_rd_busy[0], a_cnt, a_rd_data[31:0]);
    end
  endtask

  task automatic test_random_a();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      a_we = 1'($urandom); a_wa = 5'($urandom); a_wd = $urandom();
      a_ss = 1'($urandom); a_sa = ($urandom_range(0, 3) == 0) ? a_wa : 5'($urandom);
      a_rd_addr = {($urandom_range(0, 2) == 0) ? a_wa : 5'($urandom), 5'($urandom)};
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_rd_data[k*32 +: 32] !== exp_a_data(a_rd_addr[k*5 +: 5]) ||
            a_rd_busy[k] !== exp_a_busy(a_rd_addr[k*5 +: 5])) begin
          failures++;
          $display("FAIL rand_a cyc=%0d port=%0d got data=%h busy=%b exp data=%h busy=%b", c, k,
                   a_rd_data[k*32 +: 32], a_rd_busy[k], exp_a_data(a_rd_addr[k*5 +: 5]), exp_a_busy(a_rd_addr[k*5 +: 5]));
        end
      end
      checks++;
      if (int'(a_cnt) != pop_a()) begin
        failures++;
        $display("FAIL rand_a_count cyc=%0d got=%0d exp=%0d", c, a_cnt, pop_a());
      end
      tick();
    end
    reset = 0; idle();
  endtask

  task automatic test_sweep();
    reset = 1; tick(); reset = 0;
    b_we = 1; b_wa = 4'd0; b_wd = 64'h0123456789ABCDEF; b_ss = 1; b_sa = 4'd0; tick();
    idle(); b_rd_addr = '0; #1;
    checks++;
    if (b_rd_data[63:0] !== 64'h0123456789ABCDEF || b_rd_busy !== 4'hF || b_cnt !== 5'd1) begin
      failures++;
      $display("FAIL sweep_r0 got data=%h busy=%b cnt=%0d exp 0123456789abcdef 1111 1", b_rd_data[63:0], b_rd_busy, b_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      b_ss = 1; b_sa = 4'(i); tick();
    end
    idle(); #1;
    checks++;
    if (b_cnt !== 5'd16) begin
      failures++;
      $display("FAIL sweep_busy_all got=%0d exp=16", b_cnt);
    end
    for (int c = 0; c < 300; c++) begin
      b_we = 1'($urandom); b_wa = 4'($urandom); b_wd = {$urandom(), $urandom()};
      b_ss = ($urandom_range(0, 3) == 0); b_sa = 4'($urandom);
      b_rd_addr = 16'($urandom);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (b_rd_data[k*64 +: 64] !== exp_b_data(b_rd_addr[k*4 +: 4]) ||
            b_rd_busy[k] !== exp_b_busy(b_rd_addr[k*4 +: 4])) begin
          failures++;
          $display("FAIL rand_b cyc=%0d port=%0d got data=%h busy=%b exp data=%h busy=%b", c, k,
                   b_rd_data[k*64 +: 64], b_rd_busy[k], exp_b_data(b_rd_addr[k*4 +: 4]), exp_b_busy(b_rd_addr[k*4 +: 4]));
        end
      end
      checks++;
      if (int'(b_cnt) != pop_b()) begin
        failures++;
        $display("FAIL rand_b_count cyc=%0d got=%0d exp=%0d", c, b_cnt, pop_b());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_random_a();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
